// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and constants for the debounce/synchroniser block
//
// Purpose: FSM state type, default parameter values and the counter width helper
//          used by debounce_sync.
// Contents:
//   deb_state_t        STABLE (dout agrees with input) / PENDING (change being qualified)
//   DEF_*              default parameter values
//   cnt_width()        width of the qualification counter for a given STABLE_CYCLES
package debounce_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } deb_state_t;

  localparam int   DEF_SYNC_STAGES   = 2;
  localparam int   DEF_STABLE_CYCLES = 4;
  localparam logic DEF_RESET_VALUE   = 1'b0;

  // Wide enough to hold STABLE_CYCLES itself, even though the counter stops one short.
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchroniser for a single asynchronous bit
//
// Purpose: brings an asynchronous 1-bit signal into the clk domain through
//          SYNC_STAGES back-to-back flops.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset, loads RESET_VALUE into every stage
//   d    in   asynchronous input
//   q    out  synchronised output (last stage)
module sync_chain #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;

  // Bit 0 is the metastability-catching stage; the oldest sample sits at the top.
  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronise and debounce a bouncy asynchronous input
//
// Purpose: synchronises din into clk, then only lets dout follow once the
//          synchronised value has disagreed with dout for STABLE_CYCLES
//          consecutive edges. Emits registered one-cycle rise/fall strobes
//          aligned with the first cycle of the new dout.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset
//   din   in   asynchronous raw input
//   dout  out  debounced level (registered)
//   rise  out  one-cycle pulse when dout goes 0->1 (registered)
//   fall  out  one-cycle pulse when dout goes 1->0 (registered)
//   busy  out  high while a change is being qualified
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter logic RESET_VALUE   = DEF_RESET_VALUE
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int             CW       = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic s;

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (s)
  );

  deb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          dout_q,  dout_d;
  logic          rise_q,  rise_d;
  logic          fall_q,  fall_d;
  logic          commit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;

    unique case (state_q)
      STABLE: begin
        if (s != dout_q) begin
          // The first disagreeing edge already counts as cycle one, so a
          // one-cycle filter commits straight away.
          if (STABLE_CYCLES == 1) begin
            commit = 1'b1;
          end else begin
            state_d = PENDING;
            cnt_d   = CW'(1);
          end
        end
      end
      PENDING: begin
        if (s == dout_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          commit = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase

    dout_d = dout_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (commit) begin
      state_d = STABLE;
      cnt_d   = '0;
      dout_d  = s;
      rise_d  = s;
      fall_d  = ~s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      dout_q  <= RESET_VALUE;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q == PENDING);

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - self-checking bench for debounce_sync
module tb_debounce_sync;

  localparam int   SS = 2;
  localparam int   SC = 4;
  localparam logic RV = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic dout, rise, fall, busy;

  always #5 clk = ~clk;

  debounce_sync #(
    .SYNC_STAGES   (SS),
    .STABLE_CYCLES (SC),
    .RESET_VALUE   (RV)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (dout),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  // Reference model: din samples in flight through the synchroniser, and the
  // recent history of the synchronised value seen by the filter since reset.
  logic pipe[$];
  logic win[$];
  logic m_dout = RV;
  logic m_rise = 1'b0;
  logic m_fall = 1'b0;
  logic m_busy = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int edge_cnt = 0;
  int n_rise_seen = 0;
  int n_fall_seen = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  // dout follows the synchronised input only when the last SC filter samples
  // all disagree with it; busy means the latest sample still disagrees.
  task automatic model_edge();
    logic s_used;
    logic all_diff;
    s_used = pipe[0];
    if (rst) begin
      pipe.delete();
      for (int i = 0; i < SS; i++) pipe.push_back(RV);
      win.delete();
      m_dout = RV;
      m_rise = 1'b0;
      m_fall = 1'b0;
      m_busy = 1'b0;
    end else begin
      void'(pipe.pop_front());
      pipe.push_back(din);
      win.push_back(s_used);
      if (win.size() > SC) void'(win.pop_front());
      all_diff = (win.size() == SC);
      foreach (win[i]) if (win[i] == m_dout) all_diff = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (all_diff) begin
        m_dout = s_used;
        m_rise = s_used;
        m_fall = !s_used;
      end
      m_busy = (s_used != m_dout);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    edge_cnt++;
    @(negedge clk);
    if (rise) n_rise_seen++;
    if (fall) n_fall_seen++;
    chk("model_dout", dout, m_dout);
    chk("model_rise", rise, m_rise);
    chk("model_fall", fall, m_fall);
    chk("model_busy", busy, m_busy);
    chk("rise_fall_excl", rise & fall, 0);
  endtask

  initial begin
    int hold;
    int r0, f0;
    for (int i = 0; i < SS; i++) pipe.push_back(RV);
    @(negedge clk);

    // Reset with din held high, then release: dout rises on the 6th edge.
    din = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rise", rise, 0);
    rst = 1'b0;
    repeat (5) tick();
    chk("rel_dout_e5", dout, 0);
    tick();
    chk("rel_dout_e6", dout, 1);
    chk("rel_rise_e6", rise, 1);
    tick();
    chk("rel_rise_e7", rise, 0);

    // Clean fall.
    din = 1'b0;
    repeat (3) tick();
    chk("fall_busy_e3", busy, 1);
    repeat (2) tick();
    chk("fall_busy_e5", busy, 1);
    chk("fall_dout_e5", dout, 1);
    tick();
    chk("fall_dout_e6", dout, 0);
    chk("fall_pulse_e6", fall, 1);
    chk("fall_norise_e6", rise, 0);
    tick();
    chk("fall_pulse_e7", fall, 0);

    // Clean rise.
    din = 1'b1;
    repeat (3) tick();
    chk("rise_busy_e3", busy, 1);
    repeat (2) tick();
    chk("rise_dout_e5", dout, 0);
    tick();
    chk("rise_dout_e6", dout, 1);
    chk("rise_pulse_e6", rise, 1);
    tick();
    chk("rise_pulse_e7", rise, 0);

    // Back to 0, then a three-cycle glitch.
    din = 1'b0;
    repeat (8) tick();
    r0 = n_rise_seen;
    din = 1'b1;
    repeat (3) tick();
    din = 1'b0;
    repeat (8) tick();
    chk("glitch_dout", dout, 0);
    chk("glitch_busy", busy, 0);
    chk("glitch_cnt", int'(dut.cnt_q), 0);
    chk("glitch_norise", n_rise_seen - r0, 0);

    // Bounce burst then settle high.
    r0 = n_rise_seen;
    f0 = n_fall_seen;
    for (int i = 0; i < 20; i++) begin
      din = ~din;
      tick();
    end
    din = 1'b1;
    repeat (5) tick();
    chk("bounce_dout_e5", dout, 0);
    tick();
    chk("bounce_rise_e6", rise, 1);
    repeat (4) tick();
    chk("bounce_one_rise", n_rise_seen - r0, 1);
    chk("bounce_no_fall", n_fall_seen - f0, 0);

    // Reset mid-count while qualifying a fall.
    din = 1'b0;
    repeat (4) tick();
    chk("midrst_busy_pre", busy, 1);
    chk("midrst_cnt_pre", int'(dut.cnt_q), 2);
    r0 = n_rise_seen;
    f0 = n_fall_seen;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_cnt", int'(dut.cnt_q), 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_dout", dout, 0);
    chk("midrst_nopulse", (n_rise_seen - r0) + (n_fall_seen - f0), 0);
    repeat (6) tick();

    // Randomised run with occasional resets, checked against the model.
    for (int it = 0; it < 600; it++) begin
      hold = $urandom_range(1, 7);
      din = 1'($urandom);
      rst = ($urandom_range(0, 59) == 0);
      tick();
      rst = 1'b0;
      repeat (hold - 1) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
